// File: rtl/wavegen_pkg.sv
// Shared definitions for the wavegen driver and the generator top's waveform decode:
// waveform select codes, driver FSM encoding and a counter-width helper.
package wavegen_pkg;

    typedef enum logic [1:0] {
        SINUS        = 2'd0,
        SQUARE_PULSE = 2'd1,
        SAWTOOTH     = 2'd2,
        TRIANGLE     = 2'd3
    } waveform_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_PH  = 2'd1,
        ST_LOAD_AMP = 2'd2,
        ST_SETTLE   = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wavegen_driver_sample_fifo.sv
// First-word fall-through sample FIFO with sticky overflow; reads from an empty FIFO
// keep presenting the last popped word.
module sample_fifo
    import wavegen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    input  logic                  clear_overflow_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic [DATA_WIDTH-1:0] head;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop, drop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);
    assign drop    = push_i & full_o & ~pop_i;

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign data_o     = empty_o ? last_q : head;
    assign overflow_o = overflow_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_d     = do_pop  ? head : last_q;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: flops use non-blocking assignments only; blocking ones would race between processes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/wavegen_driver.sv
// Host-side driver for the CORDIC waveform generator: turns one config command into the
// phase/amplitude load sequence and captures generator samples into a FIFO.
module wavegen_driver
    import wavegen_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_phase_i,
    input  logic [DATA_WIDTH-1:0] cmd_amplitude_i,
    input  logic [1:0]            cmd_waveform_i,
    input  logic                  run_i,
    output logic [DATA_WIDTH-1:0] value_o,
    output logic                  set_phase_o,
    output logic                  set_amplitude_o,
    output logic [1:0]            waveform_o,
    output logic                  enable_o,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_strobe_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o,
    input  logic                  clear_overflow_i,
    output logic                  busy_o
);

    localparam int            CW          = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [DATA_WIDTH-1:0] amp_q, amp_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    waveform_e             waveform_q, waveform_d;
    logic                  set_phase_q, set_phase_d;
    logic                  set_amp_q, set_amp_d;
    logic                  enable_q, enable_d;
    logic                  ready_q, ready_d;
    logic                  accept, push;

    assign accept = cmd_valid_i & ready_q;
    assign push   = sample_valid_strobe_i & enable_q & (state_q == ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // The settle count spans the amplitude-load cycle too, so the next accept lands
    // exactly SETTLE_CYCLES+2 cycles after the previous one.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD_PH;
            end
            ST_LOAD_PH: begin
                state_d      = ST_LOAD_AMP;
                settle_cnt_d = SETTLE_LOAD;
            end
            ST_LOAD_AMP, ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the generator never
    // sees a combinational path from the command inputs.
    always_comb begin
        value_d     = value_q;
        amp_d       = amp_q;
        waveform_d  = waveform_q;
        set_phase_d = 1'b0;
        set_amp_d   = 1'b0;
        enable_d    = 1'b0;
        ready_d     = (state_d == ST_IDLE);
        if (state_q == ST_IDLE) begin
            if (accept) begin
                amp_d      = cmd_amplitude_i;
                waveform_d = waveform_e'(cmd_waveform_i);
            end else begin
                enable_d = run_i;
            end
        end
        if (state_d == ST_LOAD_PH) begin
            value_d     = cmd_phase_i;
            set_phase_d = 1'b1;
        end else if (state_d == ST_LOAD_AMP) begin
            value_d   = amp_q;
            set_amp_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            amp_q       <= '0;
            value_q     <= '0;
            waveform_q  <= SINUS;
            set_phase_q <= 1'b0;
            set_amp_q   <= 1'b0;
            enable_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            amp_q       <= amp_d;
            value_q     <= value_d;
            waveform_q  <= waveform_d;
            set_phase_q <= set_phase_d;
            set_amp_q   <= set_amp_d;
            enable_q    <= enable_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready_o     = ready_q;
    assign value_o         = value_q;
    assign set_phase_o     = set_phase_q;
    assign set_amplitude_o = set_amp_q;
    assign waveform_o      = waveform_q;
    assign enable_o        = enable_q;
    assign busy_o          = (state_q != ST_IDLE);

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .push_i           (push),
        .data_i           (sample_i),
        .pop_i            (rd_en_i),
        .clear_overflow_i (clear_overflow_i),
        .data_o           (rd_data_o),
        .empty_o          (fifo_empty_o),
        .full_o           (fifo_full_o),
        .overflow_o       (overflow_o)
    );

endmodule

// File: tb/tb_wavegen_driver.sv
// Self-checking bench for wavegen_driver: directed scenarios plus randomized traffic,
// compared every cycle against a timeline/queue reference model.
module tb_wavegen_driver;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [DW-1:0] cmd_phase_i = '0;
    logic [DW-1:0] cmd_amplitude_i = '0;
    logic [1:0]    cmd_waveform_i = '0;
    logic          run_i = 1'b0;
    logic [DW-1:0] value_o;
    logic          set_phase_o, set_amplitude_o;
    logic [1:0]    waveform_o;
    logic          enable_o;
    logic [DW-1:0] sample_i = '0;
    logic          sample_valid_strobe_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic          fifo_empty_o, fifo_full_o, overflow_o;
    logic          clear_overflow_i = 1'b0;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    wavegen_driver #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .cmd_phase_i           (cmd_phase_i),
        .cmd_amplitude_i       (cmd_amplitude_i),
        .cmd_waveform_i        (cmd_waveform_i),
        .run_i                 (run_i),
        .value_o               (value_o),
        .set_phase_o           (set_phase_o),
        .set_amplitude_o       (set_amplitude_o),
        .waveform_o            (waveform_o),
        .enable_o              (enable_o),
        .sample_i              (sample_i),
        .sample_valid_strobe_i (sample_valid_strobe_i),
        .rd_en_i               (rd_en_i),
        .rd_data_o             (rd_data_o),
        .fifo_empty_o          (fifo_empty_o),
        .fifo_full_o           (fifo_full_o),
        .overflow_o            (overflow_o),
        .clear_overflow_i      (clear_overflow_i),
        .busy_o                (busy_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: m_k counts cycles since the last accept (0 = idle), the FIFO is a queue.
    int            m_k;
    bit            m_live;
    logic [DW-1:0] m_value, m_amp, m_last;
    logic [1:0]    m_wave;
    logic          m_enable, m_ovf;
    logic [DW-1:0] m_q[$];

    function automatic void model_reset();
        m_k = 0; m_live = 0; m_value = '0; m_amp = '0; m_last = '0;
        m_wave = '0; m_enable = 1'b0; m_ovf = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit idle   = (m_k == 0);
        bit accept = cmd_valid_i && idle && m_live;
        bit push   = sample_valid_strobe_i && m_enable && idle;
        bit pop    = rd_en_i && (m_q.size() > 0);
        bit drop   = push && (m_q.size() == DEPTH) && !rd_en_i;
        if (pop) m_last = m_q.pop_front();
        if (push && !drop) m_q.push_back(sample_i);
        if (drop) m_ovf = 1'b1;
        else if (clear_overflow_i) m_ovf = 1'b0;
        m_enable = (idle && !accept) ? run_i : 1'b0;
        if (accept) begin
            m_k = 1; m_value = cmd_phase_i; m_amp = cmd_amplitude_i; m_wave = cmd_waveform_i;
        end else if (m_k == 1) begin
            m_k = 2; m_value = m_amp;
        end else if (m_k >= 2) begin
            m_k = (m_k + 1 > SETTLE + 1) ? 0 : m_k + 1;
        end
        m_live = 1;
    endfunction

    task automatic check_outputs(input string ph);
        bit idle = (m_k == 0);
        check({ph, " cmd_ready"}, cmd_ready_o, idle && m_live);
        check({ph, " busy"}, busy_o, !idle);
        check({ph, " set_phase"}, set_phase_o, m_k == 1);
        check({ph, " set_amplitude"}, set_amplitude_o, m_k == 2);
        check({ph, " value"}, value_o, m_value);
        check({ph, " waveform"}, waveform_o, m_wave);
        check({ph, " enable"}, enable_o, m_enable);
        check({ph, " empty"}, fifo_empty_o, m_q.size() == 0);
        check({ph, " full"}, fifo_full_o, m_q.size() == DEPTH);
        check({ph, " overflow"}, overflow_o, m_ovf);
        check({ph, " rd_data"}, rd_data_o, (m_q.size() > 0) ? m_q[0] : m_last);
    endtask

    // One clock cycle: check at the falling edge, advance the model, resume 1ns after rise.
    task automatic tick(input string ph);
        @(negedge clk_i);
        check_outputs(ph);
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    logic [DW-1:0] t4_want [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    logic [DW-1:0] t6_ph   [2] = '{8'h11, 8'h22};
    logic [DW-1:0] t6_amp  [2] = '{8'h33, 8'h44};
    logic [1:0]    t6_wave [2] = '{2'd1, 2'd2};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int n_ph;
        bit acc;

        // Power-on reset.
        model_reset();
        #1 rst_i = 1'b0;
        #2;
        check("por value", value_o, 0);
        check("por ready", cmd_ready_o, 0);
        check("por empty", fifo_empty_o, 1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        tick("por");
        check("por ready after release", cmd_ready_o, 1);

        // Single command: strobe timing and return to idle.
        cmd_valid_i = 1'b1; cmd_phase_i = 8'h40; cmd_amplitude_i = 8'h7F; cmd_waveform_i = 2'd3;
        tick("t2");
        cmd_valid_i = 1'b0;
        check("t2 set_phase T+1", set_phase_o, 1);
        check("t2 value T+1", value_o, 8'h40);
        tick("t2");
        check("t2 set_amplitude T+2", set_amplitude_o, 1);
        check("t2 value T+2", value_o, 8'h7F);
        check("t2 waveform", waveform_o, 3);
        for (int i = 0; i < SETTLE - 1; i++) tick("t2");
        check("t2 busy before idle", busy_o, 1);
        tick("t2");
        check("t2 busy idle", busy_o, 0);
        check("t2 ready idle", cmd_ready_o, 1);

        // Fill, overflow, clear.
        run_i = 1'b1;
        tick("t3");
        for (int i = 1; i <= DEPTH; i++) begin
            sample_valid_strobe_i = 1'b1; sample_i = DW'(i);
            tick("t3");
        end
        sample_i = 8'h09;
        check("t3 full", fifo_full_o, 1);
        check("t3 head", rd_data_o, 8'h01);
        tick("t3");
        sample_valid_strobe_i = 1'b0;
        check("t3 overflow", overflow_o, 1);
        clear_overflow_i = 1'b1;
        tick("t3");
        clear_overflow_i = 1'b0;

        // Push and pop together while full.
        sample_valid_strobe_i = 1'b1; sample_i = 8'h0A; rd_en_i = 1'b1;
        tick("t4");
        sample_valid_strobe_i = 1'b0; rd_en_i = 1'b0; run_i = 1'b0;
        check("t4 no overflow", overflow_o, 0);
        check("t4 still full", fifo_full_o, 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t4 pop order", rd_data_o, t4_want[i]);
            rd_en_i = 1'b1;
            tick("t4");
        end
        rd_en_i = 1'b0;
        check("t4 empty", fifo_empty_o, 1);

        // Pops on empty, strobes during load/settle.
        rd_en_i = 1'b1;
        tick("t5"); tick("t5");
        rd_en_i = 1'b0;
        check("t5 hold last head", rd_data_o, 8'h0A);
        run_i = 1'b1;
        tick("t5");
        cmd_valid_i = 1'b1; cmd_phase_i = 8'h5A; cmd_amplitude_i = 8'hA5; cmd_waveform_i = 2'd1;
        tick("t5");
        cmd_valid_i = 1'b0; sample_valid_strobe_i = 1'b1; sample_i = 8'hEE;
        for (int i = 0; i < SETTLE + 1; i++) tick("t5");
        sample_valid_strobe_i = 1'b0;
        check("t5 discard during load", fifo_empty_o, 1);

        // Command held while busy.
        idx = 0; n_ph = 0;
        for (int c = 0; c < 2 * (SETTLE + 2) + 4; c++) begin
            cmd_valid_i = (idx < 2);
            if (idx < 2) begin
                cmd_phase_i = t6_ph[idx]; cmd_amplitude_i = t6_amp[idx]; cmd_waveform_i = t6_wave[idx];
            end
            acc = cmd_valid_i && cmd_ready_o;
            if (set_phase_o) n_ph++;
            tick("t6");
            if (acc) idx++;
        end
        cmd_valid_i = 1'b0;
        check("t6 load sequences", n_ph, 2);

        // Reset in the middle of the amplitude load.
        cmd_valid_i = 1'b1; cmd_phase_i = 8'h12; cmd_amplitude_i = 8'h34; cmd_waveform_i = 2'd2;
        tick("t1");
        cmd_valid_i = 1'b0;
        tick("t1");
        check("t1 in load_amp", set_amplitude_o, 1);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check("t1 value", value_o, 0);
        check("t1 set_amplitude", set_amplitude_o, 0);
        check("t1 waveform", waveform_o, 0);
        check("t1 enable", enable_o, 0);
        check("t1 busy", busy_o, 0);
        check("t1 overflow", overflow_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        tick("t1");
        check("t1 ready after release", cmd_ready_o, 1);

        // Randomized traffic.
        run_i = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            acc = cmd_valid_i && cmd_ready_o;
            if (acc || !cmd_valid_i) begin
                cmd_valid_i     = ($urandom_range(0, 3) == 0);
                cmd_phase_i     = DW'($urandom);
                cmd_amplitude_i = DW'($urandom);
                cmd_waveform_i  = 2'($urandom);
            end
            if ($urandom_range(0, 49) == 0) run_i = ~run_i;
            sample_valid_strobe_i = $urandom_range(0, 1) == 1;
            sample_i              = DW'($urandom);
            rd_en_i               = ($urandom_range(0, 9) < 3);
            clear_overflow_i      = ($urandom_range(0, 31) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
